// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three cache-side request channels and the shared memory port.
// master = arbiter view; slave = the caches plus memory model driving the other side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              ic_read_req;
    logic [ADDR_W-1:0] ic_read_addr;
    logic              ic_read_ack;
    logic [LINE_W-1:0] ic_read_data;

    logic              dc_read_req;
    logic [ADDR_W-1:0] dc_read_addr;
    logic              dc_read_ack;
    logic [LINE_W-1:0] dc_read_data;

    logic              dc_write_req;
    logic [ADDR_W-1:0] dc_write_addr;
    logic [LINE_W-1:0] dc_write_data;
    logic              dc_write_ack;

    logic              mem_enable;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_data_out;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_data_in;

    modport master (
        input  ic_read_req, ic_read_addr, dc_read_req, dc_read_addr,
        input  dc_write_req, dc_write_addr, dc_write_data, mem_ack, mem_data_in,
        output ic_read_ack, ic_read_data, dc_read_ack, dc_read_data, dc_write_ack,
        output mem_enable, mem_rw, mem_addr, mem_data_out
    );

    modport slave (
        output ic_read_req, ic_read_addr, dc_read_req, dc_read_addr,
        output dc_write_req, dc_write_addr, dc_write_data, mem_ack, mem_data_in,
        input  ic_read_ack, ic_read_data, dc_read_ack, dc_read_data, dc_write_ack,
        input  mem_enable, mem_rw, mem_addr, mem_data_out
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 4-phase memory port between I-cache refill, D-cache refill and D-cache write-back.
// Grant one edge after req, *_ack one edge after mem_ack; losers simply keep req held until served.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);
    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SRC_IC, SRC_DR, SRC_DW} src_t;

    state_t            state_q, state_d;
    src_t              src_q, src_d, win_src;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_out_q, mem_data_out_d;
    logic              ic_ack_q, ic_ack_d;
    logic              dr_ack_q, dr_ack_d;
    logic              dw_ack_q, dw_ack_d;
    logic [LINE_W-1:0] ic_data_q, ic_data_d;
    logic [LINE_W-1:0] dc_data_q, dc_data_d;
    logic              any_req;
    logic              grant;

    assign any_req = bus.ic_read_req | bus.dc_read_req | bus.dc_write_req;

    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        starve_d       = starve_q;
        mem_enable_d   = mem_enable_q;
        mem_rw_d       = mem_rw_q;
        mem_addr_d     = mem_addr_q;
        mem_data_out_d = mem_data_out_q;
        ic_ack_d       = 1'b0;
        dr_ack_d       = 1'b0;
        dw_ack_d       = 1'b0;
        ic_data_d      = ic_data_q;
        dc_data_d      = dc_data_q;
        grant          = 1'b0;
        win_src        = SRC_IC;

        // A starved I-cache overrides the normal write > read > ifetch order.
        if (bus.ic_read_req && starve_q == CNT_MAX) begin
            win_src = SRC_IC;
        end else if (bus.dc_write_req) begin
            win_src = SRC_DW;
        end else if (bus.dc_read_req) begin
            win_src = SRC_DR;
        end else begin
            win_src = SRC_IC;
        end

        case (state_q)
            IDLE: begin
                // A leftover mem_ack (e.g. after a reset mid-transfer) must clear first.
                if (any_req && !bus.mem_ack) begin
                    grant        = 1'b1;
                    src_d        = win_src;
                    mem_enable_d = 1'b1;
                    mem_rw_d     = (win_src == SRC_DW);
                    case (win_src)
                        SRC_DW: begin
                            mem_addr_d     = bus.dc_write_addr;
                            mem_data_out_d = bus.dc_write_data;
                        end
                        SRC_DR: begin
                            mem_addr_d     = bus.dc_read_addr;
                            mem_data_out_d = '0;
                        end
                        default: begin
                            mem_addr_d     = bus.ic_read_addr;
                            mem_data_out_d = '0;
                        end
                    endcase
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    mem_enable_d = 1'b0;
                    case (src_q)
                        SRC_DW: dw_ack_d = 1'b1;
                        SRC_DR: begin
                            dr_ack_d  = 1'b1;
                            dc_data_d = bus.mem_data_in;
                        end
                        default: begin
                            ic_ack_d  = 1'b1;
                            ic_data_d = bus.mem_data_in;
                        end
                    endcase
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!bus.ic_read_req) begin
            starve_d = '0;
        end else if (grant) begin
            if (win_src == SRC_IC) begin
                starve_d = '0;
            end else if (starve_q != CNT_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            src_q          <= SRC_IC;
            starve_q       <= '0;
            mem_enable_q   <= 1'b0;
            mem_rw_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_out_q <= '0;
            ic_ack_q       <= 1'b0;
            dr_ack_q       <= 1'b0;
            dw_ack_q       <= 1'b0;
            ic_data_q      <= '0;
            dc_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            starve_q       <= starve_d;
            mem_enable_q   <= mem_enable_d;
            mem_rw_q       <= mem_rw_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_out_q <= mem_data_out_d;
            ic_ack_q       <= ic_ack_d;
            dr_ack_q       <= dr_ack_d;
            dw_ack_q       <= dw_ack_d;
            ic_data_q      <= ic_data_d;
            dc_data_q      <= dc_data_d;
        end
    end

    assign bus.mem_enable   = mem_enable_q;
    assign bus.mem_rw       = mem_rw_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data_out = mem_data_out_q;
    assign bus.ic_read_ack  = ic_ack_q;
    assign bus.dc_read_ack  = dr_ack_q;
    assign bus.dc_write_ack = dw_ack_q;
    assign bus.ic_read_data = ic_data_q;
    assign bus.dc_read_data = dc_data_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level arbitration model.
module tb_mem_port_arbiter;
    localparam int AW = 32, LW = 128, SL = 4;
    localparam int IC = 0, DR = 1, DW = 2;

    typedef struct {int src; time t;} gent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    bit mem_auto = 1'b0, mem_rand = 1'b0;
    int mem_lat = 1, mem_hold = 0;
    logic auto_ack = 1'b0, man_ack = 1'b0;
    logic [LW-1:0] auto_data = '0, man_data = '0, last_resp = '0;
    bit rnd_stop = 1'b0;
    gent_t glog[$];
    time ic_raise_t = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
    assign bus.mem_ack     = mem_auto ? auto_ack : man_ack;
    assign bus.mem_data_in = mem_auto ? auto_data : man_data;

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    function automatic logic [LW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [2:0] acks();
        return {bus.dc_write_ack, bus.dc_read_ack, bus.ic_read_ack};
    endfunction

    task automatic set_req(input int k, input logic v);
        case (k)
            IC: bus.ic_read_req = v;
            DR: bus.dc_read_req = v;
            default: bus.dc_write_req = v;
        endcase
    endtask

    // Returns the number of falling edges until mem_enable is seen (100 = gave up).
    task automatic wait_en(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.mem_enable && c < 100);
    endtask

    // Memory model: ack after a latency, hold ack until enable drops, then release.
    initial begin
        int lat, hold;
        forever begin
            @(negedge clk);
            if (mem_auto && bus.mem_enable && !auto_ack) begin
                lat  = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
                hold = mem_rand ? int'($urandom_range(0, 2)) : mem_hold;
                repeat (lat) @(negedge clk);
                last_resp = rand_line();
                auto_data = last_resp;
                auto_ack  = 1'b1;
                for (int i = 0; i < 64 && bus.mem_enable; i++) @(negedge clk);
                repeat (hold) @(negedge clk);
                auto_ack = 1'b0;
            end
        end
    end

    task automatic test_reset();
        mem_auto = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.mem_enable, bus.mem_rw, acks()} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {bus.mem_enable, bus.mem_rw, acks()});
        end
        n_tests++;
        if ({bus.mem_addr, bus.mem_data_out} !== '0) begin
            n_fail++; $display("FAIL reset_bus: got %h/%h expected 0", bus.mem_addr, bus.mem_data_out);
        end
        n_tests++;
        if ({bus.ic_read_data, bus.dc_read_data} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h expected 0", bus.ic_read_data, bus.dc_read_data);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.mem_enable !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got enable %b expected 0", bus.mem_enable);
        end
    endtask

    task automatic test_single_ic();
        int c;
        logic [LW-1:0] pat;
        pat = {16{8'hA5}};
        bus.ic_read_addr = 32'h1000;
        bus.ic_read_req = 1'b1;
        wait_en(c);
        n_tests++;
        if (c !== 1 || bus.mem_rw !== 1'b0 || bus.mem_addr !== 32'h1000) begin
            n_fail++; $display("FAIL ic_grant: got lat %0d rw %b addr %h expected 1 0 1000", c, bus.mem_rw, bus.mem_addr);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.mem_enable !== 1'b1 || acks() !== 3'b000) begin
            n_fail++; $display("FAIL ic_busy_hold: got en %b acks %b expected 1 000", bus.mem_enable, acks());
        end
        man_data = pat;
        man_ack = 1'b1;
        @(negedge clk);
        n_tests++;
        if (acks() !== 3'b001 || bus.ic_read_data !== pat || bus.mem_enable !== 1'b0) begin
            n_fail++; $display("FAIL ic_ack: got acks %b data %h en %b expected 001 %h 0", acks(), bus.ic_read_data, bus.mem_enable, pat);
        end
        bus.ic_read_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (acks() !== 3'b000 || bus.ic_read_data !== pat) begin
            n_fail++; $display("FAIL ic_ack_pulse: got acks %b data %h expected 000 held", acks(), bus.ic_read_data);
        end
        man_ack = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.mem_enable !== 1'b0) begin
            n_fail++; $display("FAIL ic_no_regrant: got enable %b expected 0", bus.mem_enable);
        end
    endtask

    task automatic test_priority_all();
        int order[$];
        logic rw_seq[$];
        logic prev_en;
        logic [2:0] a;
        mem_auto = 1'b1; mem_rand = 1'b0; mem_lat = 1; mem_hold = 0;
        prev_en = 1'b0;
        bus.ic_read_addr = 32'h1100; bus.dc_read_addr = 32'h2200; bus.dc_write_addr = 32'h3300;
        bus.dc_write_data = rand_line();
        bus.ic_read_req = 1'b1; bus.dc_read_req = 1'b1; bus.dc_write_req = 1'b1;
        for (int c = 0; c < 200 && order.size() < 3; c++) begin
            @(negedge clk);
            if (bus.mem_enable && !prev_en) rw_seq.push_back(bus.mem_rw);
            prev_en = bus.mem_enable;
            a = acks();
            if (a != 3'b000) begin
                n_tests++;
                if (!$onehot(a)) begin
                    n_fail++; $display("FAIL prio_ack_onehot: got %b expected one-hot", a);
                end
                for (int k = 0; k < 3; k++) if (a[k]) begin order.push_back(k); set_req(k, 1'b0); end
            end
        end
        n_tests++;
        if (order.size() != 3 || rw_seq.size() != 3) begin
            n_fail++; $display("FAIL prio_count: got %0d acks %0d grants expected 3 3", order.size(), rw_seq.size());
        end else begin
            n_tests++;
            if (order[0] != DW || order[1] != DR || order[2] != IC) begin
                n_fail++; $display("FAIL prio_order: got %0d,%0d,%0d expected 2,1,0", order[0], order[1], order[2]);
            end
            n_tests++;
            if ({rw_seq[0], rw_seq[1], rw_seq[2]} !== 3'b100) begin
                n_fail++; $display("FAIL prio_rw: got %b%b%b expected 100", rw_seq[0], rw_seq[1], rw_seq[2]);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_starvation();
        int order[$];
        logic [2:0] a;
        bus.dc_read_addr = 32'h2400; bus.ic_read_addr = 32'h1400;
        bus.dc_read_req = 1'b1; bus.ic_read_req = 1'b1;
        for (int c = 0; c < 400 && order.size() < 10; c++) begin
            @(negedge clk);
            a = acks();
            for (int k = 0; k < 3; k++) if (a[k]) order.push_back(k);
        end
        bus.dc_read_req = 1'b0; bus.ic_read_req = 1'b0;
        n_tests++;
        if (order.size() != 10) begin
            n_fail++; $display("FAIL starve_count: got %0d grants expected 10", order.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_tests++;
                if (order[i] != (((i + 1) % (SL + 1) == 0) ? IC : DR)) begin
                    n_fail++; $display("FAIL starve_grant%0d: got src %0d expected %0d", i, order[i], (((i + 1) % (SL + 1) == 0) ? IC : DR));
                end
            end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_busy_stable();
        int c;
        logic [LW-1:0] wd;
        logic bad;
        mem_auto = 1'b0;
        wd = {4{32'hDEADBEEF}};
        bus.dc_write_addr = 32'h2040; bus.dc_write_data = wd; bus.dc_write_req = 1'b1;
        wait_en(c);
        bad = (c != 1);
        for (int i = 0; i < 4; i++) begin
            if ({bus.mem_enable, bus.mem_rw, bus.mem_addr, bus.mem_data_out} !== {2'b11, 32'h2040, wd}) bad = 1'b1;
            bus.dc_write_addr = $urandom(); bus.dc_write_data = rand_line();
            if (i == 3) bus.dc_write_req = 1'b0;
            @(negedge clk);
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL wb_stable: got addr %h data %h expected 2040 %h", bus.mem_addr, bus.mem_data_out, wd);
        end
        man_ack = 1'b1;
        @(negedge clk);
        n_tests++;
        if (acks() !== 3'b100) begin
            n_fail++; $display("FAIL wb_ack_withdrawn: got acks %b expected 100", acks());
        end
        man_ack = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.mem_enable !== 1'b0) begin
            n_fail++; $display("FAIL wb_no_regrant: got enable %b expected 0", bus.mem_enable);
        end
    endtask

    task automatic test_reset_mid_busy();
        int c;
        logic bad;
        logic [LW-1:0] d;
        bus.ic_read_addr = 32'h3000; bus.ic_read_req = 1'b1;
        wait_en(c);
        man_ack = 1'b1;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({bus.mem_enable, bus.mem_rw, acks(), bus.mem_addr, bus.mem_data_out} !== '0) begin
            n_fail++; $display("FAIL rst_busy_outputs: got en %b addr %h expected 0", bus.mem_enable, bus.mem_addr);
        end
        n_tests++;
        if ({bus.ic_read_data, bus.dc_read_data} !== '0) begin
            n_fail++; $display("FAIL rst_busy_data: got %h/%h expected 0", bus.ic_read_data, bus.dc_read_data);
        end
        @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_enable !== 1'b0 || acks() !== 3'b000) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL rst_stale_ack: got grant while mem_ack high expected none");
        end
        man_ack = 1'b0;
        wait_en(c);
        n_tests++;
        if (c != 1 || bus.mem_addr !== 32'h3000) begin
            n_fail++; $display("FAIL rst_regrant: got lat %0d addr %h expected 1 3000", c, bus.mem_addr);
        end
        d = rand_line();
        man_data = d; man_ack = 1'b1;
        @(negedge clk);
        n_tests++;
        if (acks() !== 3'b001 || bus.ic_read_data !== d) begin
            n_fail++; $display("FAIL rst_complete: got acks %b data %h expected 001 %h", acks(), bus.ic_read_data, d);
        end
        bus.ic_read_req = 1'b0; man_ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ack_held();
        int c, dr_pulses, other_pulses, en_cycles;
        bus.dc_read_addr = 32'h4000; bus.ic_read_addr = 32'h5000;
        bus.dc_read_req = 1'b1; bus.ic_read_req = 1'b1;
        wait_en(c);
        n_tests++;
        if (c != 1 || bus.mem_addr !== 32'h4000) begin
            n_fail++; $display("FAIL held_grant: got lat %0d addr %h expected 1 4000", c, bus.mem_addr);
        end
        man_data = rand_line(); man_ack = 1'b1;
        dr_pulses = 0; other_pulses = 0; en_cycles = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.dc_read_ack) begin dr_pulses++; bus.dc_read_req = 1'b0; end
            if (bus.ic_read_ack || bus.dc_write_ack) other_pulses++;
            if (bus.mem_enable) en_cycles++;
        end
        n_tests++;
        if (dr_pulses != 1 || other_pulses != 0 || en_cycles != 0) begin
            n_fail++; $display("FAIL held_single_pulse: got dr %0d other %0d en %0d expected 1 0 0", dr_pulses, other_pulses, en_cycles);
        end
        man_ack = 1'b0;
        wait_en(c);
        n_tests++;
        if (c != 2 || bus.mem_addr !== 32'h5000) begin
            n_fail++; $display("FAIL held_next_grant: got lat %0d addr %h expected 2 5000", c, bus.mem_addr);
        end
        man_ack = 1'b1;
        @(negedge clk);
        bus.ic_read_req = 1'b0; man_ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic requester(input int k);
        logic [2:0] a;
        logic [AW-1:0] ad;
        while (!rnd_stop) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            if (rnd_stop) break;
            ad = {4'(k + 1), 28'($urandom())};
            case (k)
                IC: begin bus.ic_read_addr = ad; bus.ic_read_req = 1'b1; ic_raise_t = $time; end
                DR: begin bus.dc_read_addr = ad; bus.dc_read_req = 1'b1; end
                default: begin bus.dc_write_addr = ad; bus.dc_write_data = rand_line(); bus.dc_write_req = 1'b1; end
            endcase
            do begin
                @(negedge clk);
                a = acks();
            end while (!a[k] && !rnd_stop);
            set_req(k, 1'b0);
        end
    endtask

    task automatic monitor();
        int grants, cyc, last_g, cur, dsince, exp_src;
        logic prev_en, pend_ack;
        logic [2:0] sreq, a;
        logic [AW-1:0] sa[3];
        logic [AW-1:0] gaddr;
        logic [LW-1:0] sw;
        time tpos;
        grants = 0; cyc = 0; last_g = -10; cur = IC; prev_en = 1'b0; pend_ack = 1'b0; gaddr = '0;
        while (grants < 60 && cyc < 4000) begin
            @(posedge clk);
            tpos = $time;
            sreq = {bus.dc_write_req, bus.dc_read_req, bus.ic_read_req};
            sa[IC] = bus.ic_read_addr; sa[DR] = bus.dc_read_addr; sa[DW] = bus.dc_write_addr;
            sw = bus.dc_write_data;
            @(negedge clk);
            cyc++;
            if (bus.mem_enable && !prev_en) begin
                dsince = 0;
                foreach (glog[i]) if (glog[i].t > ic_raise_t && glog[i].src != IC) dsince++;
                exp_src = (sreq[IC] && dsince >= SL) ? IC : sreq[DW] ? DW : sreq[DR] ? DR : IC;
                n_tests++;
                if ({bus.mem_rw, bus.mem_addr} !== {exp_src == DW, sa[exp_src]}) begin
                    n_fail++; $display("FAIL rnd_grant: got rw %b addr %h expected src %0d addr %h", bus.mem_rw, bus.mem_addr, exp_src, sa[exp_src]);
                end
                if (exp_src == DW) begin
                    n_tests++;
                    if (bus.mem_data_out !== sw) begin
                        n_fail++; $display("FAIL rnd_wdata: got %h expected %h", bus.mem_data_out, sw);
                    end
                end
                n_tests++;
                if (cyc - last_g < 3) begin
                    n_fail++; $display("FAIL rnd_spacing: got %0d cycles expected >= 3", cyc - last_g);
                end
                glog.push_back('{exp_src, tpos});
                cur = exp_src; gaddr = sa[exp_src]; pend_ack = 1'b1; last_g = cyc; grants++;
            end else if (bus.mem_enable) begin
                n_tests++;
                if (bus.mem_addr !== gaddr) begin
                    n_fail++; $display("FAIL rnd_addr_stable: got %h expected %h", bus.mem_addr, gaddr);
                end
            end
            prev_en = bus.mem_enable;
            a = acks();
            if (a != 3'b000) begin
                n_tests++;
                if (!pend_ack || a !== 3'(1 << cur)) begin
                    n_fail++; $display("FAIL rnd_ack: got %b expected one pulse for src %0d", a, cur);
                end else if (cur != DW) begin
                    n_tests++;
                    if ((cur == IC ? bus.ic_read_data : bus.dc_read_data) !== last_resp) begin
                        n_fail++; $display("FAIL rnd_rdata: got %h expected %h", (cur == IC ? bus.ic_read_data : bus.dc_read_data), last_resp);
                    end
                end
                pend_ack = 1'b0;
            end
        end
        n_tests++;
        if (grants < 60) begin
            n_fail++; $display("FAIL rnd_progress: got %0d grants expected 60", grants);
        end
        rnd_stop = 1'b1;
    endtask

    task automatic test_random();
        mem_auto = 1'b1; mem_rand = 1'b1;
        glog.delete();
        ic_raise_t = $time;
        rnd_stop = 1'b0;
        fork
            requester(IC);
            requester(DR);
            requester(DW);
            monitor();
        join
        bus.ic_read_req = 1'b0; bus.dc_read_req = 1'b0; bus.dc_write_req = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        bus.ic_read_req = 1'b0; bus.ic_read_addr = '0;
        bus.dc_read_req = 1'b0; bus.dc_read_addr = '0;
        bus.dc_write_req = 1'b0; bus.dc_write_addr = '0; bus.dc_write_data = '0;
        test_reset();
        test_single_ic();
        test_priority_all();
        test_starvation();
        test_busy_stable();
        test_reset_mid_busy();
        test_ack_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
